serial_word_accumulator: RTL and testbench

//  Downstream of the 8-input bit-serial adder tree. Deserializes the tree's LSB-first serial sum

---
 rtl/serial_word_accumulator.sv | 96 +++++++++
 tb/tb_serial_word_accumulator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_word_accumulator.sv
// serial_word_accumulator: deserializes LSB-first serial words and sums acc_len of them into a result.
// Define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module serial_word_accumulator #(
   parameter int WORD_W = 12,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic             sbit,
   input  logic [CNT_W-1:0] acc_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy,
   output logic             proto_err,
   output logic             lost,
   output logic             sat
);
   localparam int KW = $clog2(WORD_W);
   typedef enum logic {IDLE, SHIFT} state_t;
   typedef struct packed {
      state_t            state;
      logic [KW-1:0]     k;
      logic [WORD_W-1:0] sh;
      logic              pend;
      logic [CNT_W-1:0]  cnt;
      logic [CNT_W-1:0]  len;
      logic [ACC_W-1:0]  acc;
      logic [ACC_W-1:0]  data;
      logic              valid;
      logic              perr;
      logic              lost;
      logic              sat;
   } regs_t;
   regs_t r;
   logic [ACC_W-1:0] word_x, sum, res;
   logic last, fresh, clamp;
   always_comb begin
      word_x = ACC_W'($signed(r.sh));
      sum = r.acc + word_x;
`ifdef ACC_SAT_EN
      clamp = (r.acc[ACC_W-1] == word_x[ACC_W-1]) && (sum[ACC_W-1] != r.acc[ACC_W-1]);
      res = clamp ? {r.acc[ACC_W-1], {(ACC_W-1){~r.acc[ACC_W-1]}}} : sum;
`else
      clamp = 1'b0;
      res = sum;
`endif
      last = (r.cnt + CNT_W'(1)) == r.len;
      // a pending final word means the next start already belongs to a new group
      fresh = r.pend ? last : (r.cnt == '0);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) r <= '0;
      else if (clear) r <= '0;
      else begin
         r.pend <= 1'b0;
         if (start) begin
            r.state <= SHIFT;
            r.sh[0] <= sbit;
            r.k <= KW'(1);
            if (r.state == SHIFT) r.perr <= 1'b1;
            if (fresh) r.len <= (acc_len == '0) ? CNT_W'(1) : acc_len;
         end else if (r.state == SHIFT) begin
            r.sh[r.k] <= sbit;
            r.k <= r.k + KW'(1);
            if (r.k == KW'(WORD_W - 1)) begin
               r.state <= IDLE;
               r.pend <= 1'b1;
            end
         end
         if (r.valid && out_ready) r.valid <= 1'b0;
         if (r.pend) begin
            if (clamp) r.sat <= 1'b1;
            if (last) begin
               r.acc <= '0;
               r.cnt <= '0;
               if (!r.valid || out_ready) begin
                  r.data <= res;
                  r.valid <= 1'b1;
               end else r.lost <= 1'b1;
            end else begin
               r.acc <= res;
               r.cnt <= r.cnt + CNT_W'(1);
            end
         end
      end
   assign out_valid = r.valid;
   assign out_data = r.data;
   assign busy = (r.state == SHIFT) || (r.cnt != '0) || r.pend;
   assign proto_err = r.perr;
   assign lost = r.lost;
   assign sat = r.sat;
endmodule

// File: tb/tb_serial_word_accumulator.sv
// tb_serial_word_accumulator: table-driven group vectors plus directed corner-case sequences.
module tb_serial_word_accumulator;
   logic clk, reset, clear, start, sbit, out_ready;
   logic [7:0] acc_len;
   logic v1, b1, pe1, l1, s1, v2, b2, pe2, l2, s2;
   logic [15:0] d1;
   logic [7:0] d2;
   int total = 0, bad = 0;

   serial_word_accumulator #(.WORD_W(8), .ACC_W(16), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .sbit(sbit), .acc_len(acc_len),
      .out_valid(v1), .out_ready(out_ready), .out_data(d1), .busy(b1), .proto_err(pe1),
      .lost(l1), .sat(s1));
   serial_word_accumulator #(.WORD_W(8), .ACC_W(8), .CNT_W(8)) u2 (
      .clk(clk), .reset(reset), .clear(clear), .start(start), .sbit(sbit), .acc_len(acc_len),
      .out_valid(v2), .out_ready(out_ready), .out_data(d2), .busy(b2), .proto_err(pe2),
      .lost(l2), .sat(s2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  len;
      int          n;
      logic [31:0] w;
      logic [15:0] exp;
   } vec_t;
   vec_t v[6];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_word(logic [7:0] w, int n = 8);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = (i == 0);
         sbit = w[i];
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
         sbit = 1'b0;
      end
   endtask

   initial begin
      v[0] = '{8'd1, 1, 32'h0000_0005, 16'h0005};
      v[1] = '{8'd3, 3, 32'h00FF_017F, 16'h007F};
      v[2] = '{8'd2, 2, 32'h0000_8080, 16'hFF00};
      v[3] = '{8'd0, 1, 32'h0000_002A, 16'h002A};
      v[4] = '{8'd4, 4, 32'h0403_0201, 16'h000A};
      v[5] = '{8'd2, 2, 32'h0000_FEFF, 16'hFFFD};
      reset = 1'b1; clear = 1'b0; start = 1'b0; sbit = 1'b0; out_ready = 1'b1; acc_len = 8'd1;
      idle(3);
      chk("rst_valid", 32'(v1), 0);
      chk("rst_data", 32'(d1), 0);
      chk("rst_busy", 32'(b1), 0);
      chk("rst_flags", {pe1, l1, s1}, 0);
      reset = 1'b0;
      idle(2);
      // acc_len is changed after each first word; latched length must hold
      for (int t = 0; t < 6; t++) begin
         acc_len = v[t].len;
         for (int j = 0; j < v[t].n; j++) begin
            send_word(v[t].w[j*8 +: 8]);
            acc_len = 8'd1;
         end
         idle(1);
         chk($sformatf("v%0d_early", t), {v1, b1}, 2'b01);
         idle(1);
         chk($sformatf("v%0d_valid", t), {v1, b1}, 2'b10);
         chk($sformatf("v%0d_data", t), 32'(d1), 32'(v[t].exp));
         idle(1);
         chk($sformatf("v%0d_drop", t), 32'(v1), 0);
      end
      // reset mid-word in the third word of a 3-word group
      acc_len = 8'd3;
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33, 3);
      @(negedge clk);
      start = 1'b0;
      chk("pre_rst_busy", 32'(b1), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_out", {v1, b1, pe1, l1, s1}, 0);
      chk("mid_rst_data", 32'(d1), 0);
      @(negedge clk);
      reset = 1'b0;
      acc_len = 8'd1;
      send_word(8'h80);
      idle(2);
      chk("post_rst", {v1, d1}, {1'b1, 16'hFF80});
      idle(1);
      // sink stall: second result is dropped, held one stays
      out_ready = 1'b0;
      send_word(8'h03);
      idle(2);
      chk("stall_first", {v1, d1}, {1'b1, 16'h0003});
      send_word(8'h04);
      idle(2);
      chk("stall_hold", {v1, d1}, {1'b1, 16'h0003});
      chk("stall_lost", 32'(l1), 1);
      out_ready = 1'b1;
      idle(1);
      chk("stall_hs", 32'(v1), 0);
      // clear wins over a simultaneous start
      @(negedge clk);
      clear = 1'b1; start = 1'b1; sbit = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0; sbit = 1'b0;
      chk("clear_start", {b1, l1, pe1}, 0);
      // start re-asserted at bit 4 restarts the word
      acc_len = 8'd1;
      send_word(8'hAB, 4);
      send_word(8'h10);
      idle(2);
      chk("perr_flag", 32'(pe1), 1);
      chk("perr_data", {v1, d1}, {1'b1, 16'h0010});
      idle(1);
      chk("perr_idle", {v1, b1}, 0);
      // narrow accumulator overflow
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      acc_len = 8'd2;
      send_word(8'h7F);
      send_word(8'h7F);
      idle(2);
      chk("wide_sum", {v1, d1, s1}, {1'b1, 16'h00FE, 1'b0});
`ifdef ACC_SAT_EN
      chk("narrow_sum", {v2, d2, s2}, {1'b1, 8'h7F, 1'b1});
`else
      chk("narrow_sum", {v2, d2, s2}, {1'b1, 8'hFE, 1'b0});
`endif
      chk("narrow_flags", {b2, pe2, l2}, 0);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
